// File: rtl/vram_arbiter_if.sv
// Bundle of CPU, video-consumer and VRAM signals around the VRAM arbiter.
// The arbiter uses the slave view; the surrounding CPU, pixel stage and RAM use master.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vid_start;
    logic              vid_pop;
    logic [DATA_W-1:0] vid_pixel;
    logic              vid_valid;
    logic              vid_underrun;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_start, vid_pop, mem_rdata,
        output cpu_ack, cpu_rdata, vid_pixel, vid_valid, vid_underrun,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_start, vid_pop, mem_rdata,
        input  cpu_ack, cpu_rdata, vid_pixel, vid_valid, vid_underrun,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: keeps a pixel prefetch FIFO topped up from sequential
// frame-buffer addresses and gives the CPU the slots the display can spare.
module vram_arbiter #(
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FRAME_PIXELS = 307200,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned LOW_WATER    = 2
) (
    input logic           clk_i,
    input logic           reset_b_i,
    vram_arbiter_if.slave bus_io
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned CrdW = PtrW + 2;
    localparam logic [CrdW-1:0]   Depth    = CrdW'(FIFO_DEPTH);
    localparam logic [CrdW-1:0]   LowWater = CrdW'(LOW_WATER);
    localparam logic [ADDR_W-1:0] LastPix  = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StAck} cpu_state_e;

    cpu_state_e        cpu_state_q;
    logic              cpu_ack_q;
    logic              cpu_rd_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              vid_fetch_q;  // mem_* in this cycle is a video read
    logic              vid_pend_q;   // mem_rdata in this cycle carries a video pixel
    logic [ADDR_W-1:0] fetch_ptr_q;
    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              underrun_q;

    logic              fifo_empty;
    logic              vid_valid;
    logic              pop_ok;
    logic              fifo_rd;
    logic              push;
    logic [CrdW-1:0]   credit;
    logic              cpu_want;
    logic              grant_cpu;
    logic              grant_vid;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] fetch_next;

    always_comb begin
        fifo_empty = (count_q == '0);
        vid_valid  = !fifo_empty || vid_pend_q;
        pop_ok     = bus_io.vid_pop && vid_valid;
        fifo_rd    = pop_ok && !fifo_empty;
        // An empty FIFO hands the returning word straight to the consumer.
        push       = vid_pend_q && !bus_io.vid_start && !(pop_ok && fifo_empty);
        // Credit covers stored pixels, the word on mem_rdata and the read on the bus now.
        if (bus_io.vid_start) begin
            credit = '0;
        end else begin
            credit = CrdW'(count_q) + CrdW'(vid_pend_q) + CrdW'(vid_fetch_q) - CrdW'(pop_ok);
        end
        cpu_want   = (cpu_state_q == StIdle) && bus_io.cpu_req && !cpu_ack_q;
        grant_vid  = (credit < LowWater) || (!cpu_want && (credit < Depth));
        grant_cpu  = cpu_want && !(credit < LowWater);
        fetch_addr = bus_io.vid_start ? '0 : fetch_ptr_q;
        fetch_next = (fetch_addr == LastPix) ? '0 : fetch_addr + ADDR_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_b_i) begin
            cpu_state_q <= StIdle;
            cpu_ack_q   <= 1'b0;
            cpu_rd_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            vid_fetch_q <= 1'b0;
            vid_pend_q  <= 1'b0;
            fetch_ptr_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            underrun_q  <= 1'b0;
        end else begin
            mem_en_q    <= grant_cpu || grant_vid;
            mem_we_q    <= grant_cpu && bus_io.cpu_we;
            mem_addr_q  <= grant_cpu ? bus_io.cpu_addr : (grant_vid ? fetch_addr : '0);
            mem_wdata_q <= (grant_cpu && bus_io.cpu_we) ? bus_io.cpu_wdata : '0;
            vid_fetch_q <= grant_vid;
            vid_pend_q  <= vid_fetch_q && !bus_io.vid_start;
            if (grant_vid) begin
                fetch_ptr_q <= fetch_next;
            end

            if (bus_io.vid_start) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (fifo_rd) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                end
                count_q <= count_q + CntW'(push) - CntW'(fifo_rd);
            end

            if (bus_io.vid_pop && !vid_valid) begin
                underrun_q <= 1'b1;
            end

            unique case (cpu_state_q)
                StIdle: begin
                    if (grant_cpu) begin
                        cpu_state_q <= StIssue;
                        cpu_rd_q    <= !bus_io.cpu_we;
                    end
                end
                StIssue: begin
                    cpu_state_q <= StAck;
                    cpu_ack_q   <= 1'b1;
                end
                StAck: begin
                    cpu_state_q <= StIdle;
                    cpu_ack_q   <= 1'b0;
                end
                default: begin
                    cpu_state_q <= StIdle;
                    cpu_ack_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bus_io.mem_rdata;
        end
    end

    assign bus_io.cpu_ack      = cpu_ack_q;
    assign bus_io.cpu_rdata    = (cpu_ack_q && cpu_rd_q) ? bus_io.mem_rdata : '0;
    assign bus_io.vid_valid    = vid_valid;
    assign bus_io.vid_pixel    = !fifo_empty ? fifo_q[rd_ptr_q]
                                             : (vid_pend_q ? bus_io.mem_rdata : '0);
    assign bus_io.vid_underrun = underrun_q;
    assign bus_io.mem_en       = mem_en_q;
    assign bus_io.mem_we       = mem_we_q;
    assign bus_io.mem_addr     = mem_addr_q;
    assign bus_io.mem_wdata    = mem_wdata_q;
endmodule
